image_reader: RTL and testbench
===============================

IMAGE_READER -- requirements
Module: image_reader

Interface
REQ-001 Parameter RAM_DEPTH, default 65536: number of pixels in one frame.
REQ-002 Parameter IMG_WIDTH, default 256: pixels per row, used for end-of-line marking.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: single-cycle pulse requesting one full frame read, honoured only in IDLE.
REQ-006 Port busy, output, 1: high in every state except IDLE.
REQ-007 Port done, output, 1: one-cycle pulse after the last pixel is accepted downstream.
REQ-008 Port rd_en, output, 1: RAM read strobe.
REQ-009 Port rd_addr, output, clog2(RAM_DEPTH)+1 (17 at default): RAM read address, with the MSB always 0.
REQ-010 Port rd_data, input, 8: RAM read data, valid exactly 2 cycles after the cycle rd_en was high, for one cycle only.
REQ-011 Port pix_data, output, 8: streamed pixel value.
REQ-012 Port pix_valid, output, 1: pix_data is valid.
REQ-013 Port pix_ready, input, 1: downstream accepts the pixel when pix_valid and pix_ready are both high.

Function
REQ-014 States are IDLE, READ, DRAIN and DONE. IDLE goes to READ on start. READ goes to DRAIN after issuing address RAM_DEPTH-1. DRAIN goes to DONE when no reads are in flight and the FIFO is empty. DONE returns to IDLE after one cycle.
REQ-015 Addresses are issued in raster order 0..RAM_DEPTH-1, each exactly once per frame, with no wrap-around; the address counter holds at RAM_DEPTH-1 after the last issue.
REQ-016 A 2-stage in-flight valid shift register tracks outstanding reads; rd_data is written into the FIFO at the end of the cycle in which stage 2 is set.
REQ-017 The output FIFO is 4 entries deep, and pix_data/pix_valid are driven from the FIFO head.
REQ-018 rd_en is asserted in READ only when (FIFO occupancy + in-flight count) < 4; this credit rule guarantees returning data is never dropped.
REQ-019 A simultaneous FIFO push and pop leaves occupancy unchanged, and the order of pixels is preserved.
REQ-020 With pix_ready held high, sustained throughput is 1 pixel per cycle. The first rd_en occurs in the cycle after start, and the first pix_valid occurs 3 cycles after the first rd_en.
REQ-021 pix_data holds stable while pix_valid is high and pix_ready is low.
REQ-022 start is ignored while busy is high.
REQ-023 done is asserted in DONE only.

Reset
REQ-024 On rst_n low, the block immediately enters IDLE and the FIFO and in-flight register are cleared.
REQ-025 Every output resets to 0: busy, done, rd_en, rd_addr, pix_valid and pix_data.
REQ-026 A reset asserted mid-frame abandons the frame. Data arriving on rd_data after reset is discarded, and no done pulse is produced.
REQ-027 Reset release is synchronised internally, and state updates start on the second clk edge after rst_n rises.

Configuration
REQ-028 Macro IMAGE_READER_MARKERS_EN, when defined, adds output ports pix_sof (1 bit) and pix_eol (1 bit), both carried through the FIFO alongside pix_data.
REQ-029 pix_sof is high with pixel 0. pix_eol is high with every pixel whose address mod IMG_WIDTH equals IMG_WIDTH-1.
REQ-030 When IMAGE_READER_MARKERS_EN is not defined, these ports and their FIFO storage are absent, and all other behaviour is identical.

Verification
REQ-031 RAM preloaded mem[i]=i mod 256, start pulse, pix_ready tied high: the bench receives 65536 pixels in order 0,1,..,255,0,..; done pulses once; rd_en is high for exactly 65536 cycles.
REQ-032 Same preload with pix_ready toggling 1 cycle on, 3 cycles off: no pixel is lost or duplicated, pix_data is stable while stalled, and FIFO occupancy plus in-flight count never exceeds 4.
REQ-033 Start pulse with pix_ready low for 20 cycles: exactly 4 rd_en pulses are issued, then rd_en stays low until pix_ready rises.
REQ-034 rst_n pulsed low at pixel 1000: all outputs are 0 within the same cycle, no done pulse follows, and a subsequent start restarts the frame at address 0.
REQ-035 With IMAGE_READER_MARKERS_EN defined: pix_sof is high only on pixel 0, and pix_eol is high on pixels 255, 511, ..., 65535, giving 256 pulses total.
REQ-036 A start pulse issued while busy is high: it is ignored, and the frame count is still 65536 pixels with one done pulse.

Source files
------------

// File: rtl/image_reader.sv
// rtl/image_reader.sv - Raster frame reader: RAM reads streamed through a 4-entry credit-limited FIFO
// Optional start-of-frame / end-of-line markers are enabled with IMAGE_READER_MARKERS_EN.
module image_reader #(
  parameter int RAM_DEPTH = 65536,
  parameter int IMG_WIDTH = 256,
  localparam int AW = $clog2(RAM_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    pix_data,
  output logic          pix_valid,
  input  logic          pix_ready
`ifdef IMAGE_READER_MARKERS_EN
  ,
  output logic          pix_sof,
  output logic          pix_eol
`endif
);

`ifdef IMAGE_READER_MARKERS_EN
  localparam int FW = 10;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
`else
  localparam int FW = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rst_sync;
  logic [1:0]      infl;
  logic [2:0]      fifo_cnt;
  logic [2:0]      credit_used;
  logic [1:0]      wr_ptr;
  logic [1:0]      rd_ptr;
  logic [FW-1:0]   fifo_mem [4];
  logic [FW-1:0]   head;
  logic [FW-1:0]   push_word;
  logic            push;
  logic            pop;
  logic            last_addr;

  // Async assert, synchronised release: state starts moving on the 2nd edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 1'b0;
    else        rst_sync <= 1'b1;
  end

  assign last_addr   = (rd_addr == AW'(RAM_DEPTH - 1));
  assign credit_used = fifo_cnt + {2'b00, infl[0]} + {2'b00, infl[1]};
  assign push        = infl[1];
  assign pop         = pix_valid && pix_ready;
  assign head        = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= S_IDLE;
    else if (rst_sync) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        // Credit rule: every read in flight already owns a FIFO slot.
        rd_en = (credit_used < 3'd4);
        if (rd_en && last_addr) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (infl == 2'b00 && fifo_cnt == 3'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (rst_sync) begin
      if (state == S_IDLE)          rd_addr <= '0;
      else if (rd_en && !last_addr) rd_addr <= rd_addr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        infl <= 2'b00;
    else if (rst_sync) infl <= {infl[0], rd_en};
  end

`ifdef IMAGE_READER_MARKERS_EN
  logic [CW-1:0] col;
  logic [1:0]    mk_s1;
  logic [1:0]    mk_s2;

  // Markers are tagged at issue time and ride the in-flight pipe alongside the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      mk_s1 <= 2'b00;
      mk_s2 <= 2'b00;
    end else if (rst_sync) begin
      if (state == S_IDLE) col <= '0;
      else if (rd_en)      col <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + CW'(1);
      mk_s1 <= {rd_addr == '0, col == CW'(IMG_WIDTH - 1)};
      mk_s2 <= mk_s1;
    end
  end

  assign push_word = {mk_s2, rd_data};
  assign pix_sof   = pix_valid && head[9];
  assign pix_eol   = pix_valid && head[8];
`else
  assign push_word = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else if (rst_sync) begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign pix_valid = (fifo_cnt != 3'd0);
  assign pix_data  = pix_valid ? head[7:0] : 8'd0;

endmodule

// File: tb/tb_image_reader.sv
// tb/tb_image_reader.sv - Table-driven frame checks with a pixel scoreboard for image_reader
`timescale 1ns/1ps
module tb_image_reader;
  localparam int DEPTH = 64;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, pix_valid;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    pix_data;
  logic          pix_ready = 1'b0;
`ifdef IMAGE_READER_MARKERS_EN
  logic          pix_sof, pix_eol;
`endif

  always #5 clk = ~clk;

  image_reader #(.RAM_DEPTH(DEPTH), .IMG_WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
`ifdef IMAGE_READER_MARKERS_EN
    , .pix_sof(pix_sof), .pix_eol(pix_eol)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RAM model: data for a read appears 2 cycles after its rd_en cycle, for one cycle only.
  logic [7:0]    mem [DEPTH];
  logic [2:0]    r_en = 3'b000;
  logic [AW-1:0] ra0 = '0, ra1 = '0, ra2 = '0;

  always @(negedge clk) begin
    r_en[2] = r_en[1]; ra2 = ra1;
    r_en[1] = r_en[0]; ra1 = ra0;
    r_en[0] = rd_en;   ra0 = rd_addr;
    rd_data = r_en[2] ? mem[ra2[AW-2:0]] : 8'hA5;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } pix_t;

  pix_t sb[$];
  int cyc = 0, pix_cnt = 0, done_cnt = 0, rden_cnt = 0;
  int issued = 0, accepted = 0, exp_addr = 0;
  int first_rden = -1, first_pv = -1, last_done_cyc = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin : monitor
    pix_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      exp_addr = 0; issued = 0; accepted = 0; prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        sb.delete();
        exp_addr = 0; issued = 0; accepted = 0; first_rden = -1; first_pv = -1;
        for (int i = 0; i < DEPTH; i++)
          sb.push_back('{data: 8'(i % 256), sof: (i == 0), eol: ((i % WIDTH) == WIDTH - 1)});
      end
      if (rd_en) begin
        if (first_rden < 0) first_rden = cyc;
        rden_cnt++;
        issued++;
        chk("rd_addr order", int'(rd_addr), exp_addr);
        exp_addr++;
        checks++;
        if (issued - accepted > 4) begin
          errors++;
          $display("FAIL credit: got %0d outstanding expected at most 4", issued - accepted);
        end
      end
      if (prev_stall) begin
        checks++;
        if (!pix_valid || pix_data != prev_data) begin
          errors++;
          $display("FAIL stall hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                   pix_valid, pix_data, prev_data);
        end
      end
      if (pix_valid && first_pv < 0) first_pv = cyc;
      if (pix_valid && pix_ready) begin
        accepted++;
        pix_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra pixel: got data %0d expected none", pix_data);
        end else begin
          e = sb.pop_front();
          chk("pix_data", int'(pix_data), int'(e.data));
`ifdef IMAGE_READER_MARKERS_EN
          chk("pix_sof", int'(pix_sof), int'(e.sof));
          chk("pix_eol", int'(pix_eol), int'(e.eol));
`endif
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  typedef struct {
    int mode;            // 0 high, 1 one-on-three-off, 2 random, 3 low for 20 cycles
    bit restart;         // extra start pulse while busy
    int exp_pix;
    int exp_done;
    int exp_rden;
    int exp_latency;     // start cycle to done cycle, -1 = unchecked
    int exp_stall_rden;  // rd_en count after 20 stalled cycles, -1 = unchecked
  } tcase_t;

  tcase_t tbl [5];

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      1:       return (k % 4) == 0;
      2:       return 1'($urandom_range(0, 1));
      3:       return k >= 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_case(input int idx, input tcase_t tc);
    int p0, d0, r0, s0, k;
    bit fin;
    p0 = pix_cnt; d0 = done_cnt; r0 = rden_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    s0 = cyc;
    pix_ready = ready_for(tc.mode, 0);
    k = 0;
    fin = 1'b0;
    while (!fin && k < 3000) begin
      @(posedge clk); #1;
      k++;
      start = tc.restart && (k == 10);
      pix_ready = ready_for(tc.mode, k);
      if (tc.exp_stall_rden >= 0 && k == 20) begin
        chk("stall rd_en count", rden_cnt - r0, tc.exp_stall_rden);
        chk("stall rd_en low", int'(rd_en), 0);
      end
      if (done_cnt != d0) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL case %0d timeout: got no done expected done within 3000 cycles", idx);
    end
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("pixel count", pix_cnt - p0, tc.exp_pix);
    chk("done count", done_cnt - d0, tc.exp_done);
    chk("rd_en cycles", rden_cnt - r0, tc.exp_rden);
    chk("scoreboard empty", sb.size(), 0);
    chk("idle after frame", int'(busy), 0);
    chk("first rd_en latency", first_rden - s0 - 1, 1);
    chk("first pix_valid latency", first_pv - first_rden, 3);
    if (tc.exp_latency >= 0) chk("frame latency", last_done_cyc - s0 - 1, tc.exp_latency);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no summary expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, k;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i % 256);
    tbl[0] = '{0, 1'b0, DEPTH, 1, DEPTH, DEPTH + 5, -1};
    tbl[1] = '{1, 1'b0, DEPTH, 1, DEPTH, -1, -1};
    tbl[2] = '{2, 1'b0, DEPTH, 1, DEPTH, -1, -1};
    tbl[3] = '{3, 1'b0, DEPTH, 1, DEPTH, -1, 4};
    tbl[4] = '{0, 1'b1, DEPTH, 1, DEPTH, DEPTH + 5, -1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset pix_valid", int'(pix_valid), 0);
    chk("reset pix_data", int'(pix_data), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 5; i++) run_case(i, tbl[i]);

    // Reset in mid-frame: outputs clear at once, in-flight data is dropped, no done follows.
    p0 = pix_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (pix_cnt - p0 < 20 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached pixel 20", int'(pix_cnt - p0 >= 20), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset rd_en", int'(rd_en), 0);
    chk("midreset rd_addr", int'(rd_addr), 0);
    chk("midreset pix_valid", int'(pix_valid), 0);
    chk("midreset pix_data", int'(pix_data), 0);
    #5;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no done after reset", done_cnt - d0, 0);
    chk("idle after reset", int'(busy), 0);
    chk("no stale pixel", int'(pix_valid), 0);

    run_case(5, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
